// File: rtl/video_stream_pkg.sv
// Shared video stream definitions: beat widths, default alpha and packer state encoding.
package video_stream_pkg;

    localparam int unsigned RGB_W  = 24;
    localparam int unsigned RGBA_W = 32;

    localparam logic [7:0] DEFAULT_ALPHA = 8'hFF;

    typedef enum logic [1:0] {
        StSeek   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2
    } frame_state_e;

    // Places the constant alpha byte above the scaler's RGB triple.
    function automatic logic [RGBA_W-1:0] pack_rgba(input logic [7:0]       alpha,
                                                    input logic [RGB_W-1:0] rgb);
        return {alpha, rgb};
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry in-order buffer carrying a data word plus SOP/EOP flags.
// Slot 0 always holds the head beat, so the outputs come straight from registers.
module stream_skid_buffer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_sop_i,
    input  logic              push_eop_i,
    output logic              push_ready_o,
    output logic              pop_valid_o,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              pop_sop_o,
    output logic              pop_eop_o,
    input  logic              pop_ready_i
);

    localparam int unsigned EntryW = DATA_W + 2;

    logic [EntryW-1:0] slot0_q, slot0_d;
    logic [EntryW-1:0] slot1_q, slot1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [EntryW-1:0] entry;
    logic              pop;
    logic              push_ok;

    assign entry        = {push_data_i, push_sop_i, push_eop_i};
    assign pop_valid_o  = (cnt_q != 2'd0);
    assign push_ready_o = (cnt_q != 2'd2);
    assign pop          = pop_valid_o && pop_ready_i;
    // A push into a full buffer is only taken when the same-cycle pop frees a slot.
    assign push_ok      = push_i && (push_ready_o || pop);

    assign pop_data_o = slot0_q[EntryW-1:2];
    assign pop_sop_o  = slot0_q[1];
    assign pop_eop_o  = slot0_q[0];

    // Next-state slot contents and occupancy for every push/pop combination.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        case ({push_ok, pop})
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    slot0_d = entry;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = entry;
                end
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    slot0_d = entry;
                end else begin
                    slot1_d = entry;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Slot and occupancy registers; reset empties the buffer and zeroes the outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/rgba_frame_packer.sv
// Frame-aware RGB to RGBA packer: locks onto SOP, tracks pixel position, flags
// malformed frames and forwards good pixels through a two-entry output buffer.
module rgba_frame_packer
    import video_stream_pkg::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter logic [7:0]  ALPHA  = DEFAULT_ALPHA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RGB_W-1:0]  in_data,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              frame_transition,
    output logic [RGBA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              frame_error,
    output logic [15:0]       frame_count
);

    localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);
    // Position of the beat that follows pixel (0,0).
    localparam logic [XW-1:0] XAfterOrigin = (WIDTH > 1) ? XW'(1) : '0;
    localparam logic [YW-1:0] YAfterOrigin = (WIDTH > 1) ? '0 : YW'(1);

    frame_state_e  state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [15:0]   count_q, count_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          push;
    logic          push_sop;
    logic          push_eop;
    logic          buf_ready;
    logic          accept;
    logic          last_pixel;
    logic [XW-1:0] x_adv;
    logic [YW-1:0] y_adv;

    // DRAIN swallows beats unconditionally; SEEK and STREAM may push, so they only
    // take a beat when the buffer has room (always true unless downstream stalls).
    assign in_ready   = !reset && ((state_q == StDrain) || buf_ready);
    assign accept     = in_valid && in_ready;
    assign last_pixel = (x_q == XLast) && (y_q == YLast);
    assign x_adv      = (x_q == XLast) ? '0 : x_q + 1'b1;
    assign y_adv      = (x_q == XLast) ? y_q + 1'b1 : y_q;

    assign frame_done  = done_q;
    assign frame_error = err_q;
    assign frame_count = count_q;

    // Frame FSM: next state, pixel position, buffer push and status pulses.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        count_d  = count_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        push     = 1'b0;
        push_sop = 1'b0;
        push_eop = 1'b0;
        unique case (state_q)
            StSeek: begin
                if (accept) begin
                    if (in_startofpacket && in_endofpacket) begin
                        err_d = 1'b1;
                    end else if (in_startofpacket && !frame_transition) begin
                        push     = 1'b1;
                        push_sop = 1'b1;
                        x_d      = XAfterOrigin;
                        y_d      = YAfterOrigin;
                        state_d  = StStream;
                    end
                end
            end
            StStream: begin
                if (accept) begin
                    x_d = '0;
                    y_d = '0;
                    if (frame_transition) begin
                        // Abandoned frame: not an error, just wait out its EOP.
                        state_d = StDrain;
                    end else if (in_startofpacket && in_endofpacket) begin
                        err_d   = 1'b1;
                        state_d = StSeek;
                    end else if (in_startofpacket) begin
                        err_d    = 1'b1;
                        push     = 1'b1;
                        push_sop = 1'b1;
                        x_d      = XAfterOrigin;
                        y_d      = YAfterOrigin;
                    end else if (in_endofpacket) begin
                        push     = 1'b1;
                        push_eop = 1'b1;
                        state_d  = StSeek;
                        if (last_pixel) begin
                            done_d  = 1'b1;
                            count_d = count_q + 16'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (last_pixel) begin
                        // Frame is full but the source keeps going: close it ourselves.
                        push     = 1'b1;
                        push_eop = 1'b1;
                        err_d    = 1'b1;
                        state_d  = StDrain;
                    end else begin
                        push = 1'b1;
                        x_d  = x_adv;
                        y_d  = y_adv;
                    end
                end
            end
            StDrain: begin
                if (accept && in_endofpacket) begin
                    state_d = StSeek;
                    if (in_startofpacket) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StSeek;
            end
        endcase
    end

    // State, position, frame counter and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StSeek;
            x_q     <= '0;
            y_q     <= '0;
            count_q <= 16'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    stream_skid_buffer #(
        .DATA_W (RGBA_W)
    ) u_out_buf (
        .clk_i        (clk),
        .rst_i        (reset),
        .push_i       (push),
        .push_data_i  (pack_rgba(ALPHA, in_data)),
        .push_sop_i   (push_sop),
        .push_eop_i   (push_eop),
        .push_ready_o (buf_ready),
        .pop_valid_o  (out_valid),
        .pop_data_o   (out_data),
        .pop_sop_o    (out_startofpacket),
        .pop_eop_o    (out_endofpacket),
        .pop_ready_i  (out_ready)
    );

endmodule

// File: tb/tb_rgba_frame_packer.sv
// Directed bench for rgba_frame_packer (WIDTH=4, HEIGHT=2) with an output scoreboard.
module tb_rgba_frame_packer;

    logic        clk;
    logic        reset;
    logic [23:0] in_data;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic        in_valid;
    logic        in_ready;
    logic        frame_transition;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic        out_ready;
    logic        frame_done;
    logic        frame_error;
    logic [15:0] frame_count;

    logic        toggle_en;
    logic        tog;

    int nchecks = 0;
    int nfail   = 0;
    int out_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int o0, d0, e0;

    logic [33:0] exp_q[$];

    rgba_frame_packer #(
        .WIDTH  (4),
        .HEIGHT (2),
        .ALPHA  (8'hFF)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .frame_transition  (frame_transition),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_ready         (out_ready),
        .frame_done        (frame_done),
        .frame_error       (frame_error),
        .frame_count       (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial tog = 1'b1;
    always @(posedge clk) tog <= ~tog;
    assign out_ready = toggle_en ? tog : 1'b1;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every transferred beat must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) done_cnt++;
            if (frame_error) err_cnt++;
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {6'd0, out_data, out_startofpacket,
                          out_endofpacket}, 40'hFF_FFFF_FFFF);
                end else begin
                    check("out_beat", {6'd0, out_data, out_startofpacket, out_endofpacket},
                          {6'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [23:0] d, input logic sop, input logic eop,
                        input logic ft, input logic fwd, input logic esop, input logic eeop);
        logic got;
        got = 1'b0;
        in_data          = d;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        frame_transition = ft;
        in_valid         = 1'b1;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check("accept", {39'd0, got}, 40'd1);
        if (got && fwd) exp_q.push_back({8'hFF, d, esop, eeop});
        if (got) @(posedge clk);
        #2;
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        frame_transition = 1'b0;
    endtask

    task automatic frame_good(input logic [23:0] base, input logic rand_gap,
                              input logic chk_lat);
        for (int i = 0; i < 8; i++) begin
            if (rand_gap) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #2;
            end
            send(base + 24'(i), i == 0, i == 7, 1'b0, 1'b1, i == 0, i == 7);
            if (chk_lat && i == 0) begin
                check("latency_first_beat", {7'd0, out_valid, out_data},
                      {7'd0, 1'b1, 8'hFF, base});
            end
        end
    endtask

    task automatic wait_drain();
        logic empty;
        empty = 1'b0;
        for (int k = 0; k < 100 && !empty; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) empty = 1'b1;
        end
        check("drain", {39'd0, empty}, 40'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic snap();
        o0 = out_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
    endtask

    task automatic expect_counts(input string tag, input int outs, input int dones,
                                 input int errs, input int fc);
        check({tag, "_outputs"}, 40'(out_cnt - o0), 40'(outs));
        check({tag, "_done"}, 40'(done_cnt - d0), 40'(dones));
        check({tag, "_error"}, 40'(err_cnt - e0), 40'(errs));
        check({tag, "_frame_count"}, {24'd0, frame_count}, 40'(fc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        in_valid         = 1'b0;
        in_data          = '0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        frame_transition = 1'b0;
        toggle_en        = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {39'd0, out_valid}, 40'd0);
        check("rst_out_data", {8'd0, out_data}, 40'd0);
        check("rst_sop_eop", {38'd0, out_startofpacket, out_endofpacket}, 40'd0);
        check("rst_pulses", {38'd0, frame_done, frame_error}, 40'd0);
        check("rst_frame_count", {24'd0, frame_count}, 40'd0);
        check("rst_in_ready", {39'd0, in_ready}, 40'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("seek_in_ready", {39'd0, in_ready}, 40'd1);
        @(posedge clk);
        #2;

        // Good frame with first-beat latency check
        snap();
        frame_good(24'h112200, 1'b0, 1'b1);
        wait_drain();
        expect_counts("good1", 8, 1, 0, 1);

        // Leading beats without SOP are dropped
        snap();
        for (int i = 0; i < 3; i++) send(24'h0BAD00 + 24'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame_good(24'h223300, 1'b0, 1'b0);
        wait_drain();
        expect_counts("nosop", 8, 1, 0, 2);

        // Early EOP on beat 5, then a good frame
        snap();
        for (int i = 0; i < 5; i++) begin
            send(24'h334400 + 24'(i), i == 0, i == 4, 1'b0, 1'b1, i == 0, i == 4);
        end
        wait_drain();
        expect_counts("early_eop", 5, 0, 1, 2);
        snap();
        frame_good(24'h445500, 1'b0, 1'b0);
        wait_drain();
        expect_counts("after_early", 8, 1, 0, 3);

        // Missing EOP: 8th output gets a forced EOP, beats 9-10 dropped
        snap();
        for (int i = 0; i < 8; i++) begin
            send(24'h556600 + 24'(i), i == 0, 1'b0, 1'b0, 1'b1, i == 0, i == 7);
        end
        send(24'h556608, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(24'h556609, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain();
        expect_counts("late_eop", 8, 0, 1, 3);

        // SOP+EOP beat, frame_transition abandon, mid-frame SOP restart
        snap();
        send(24'h660000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(24'h660100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(24'h660101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(24'h660102, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(24'h660103, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(24'h660200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(24'h660201, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(24'h660300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            send(24'h660300 + 24'(i), 1'b0, i == 7, 1'b0, 1'b1, 1'b0, i == 7);
        end
        wait_drain();
        expect_counts("abandon_restart", 12, 1, 2, 4);

        // Toggling out_ready with random input gaps
        snap();
        toggle_en = 1'b1;
        frame_good(24'h778800, 1'b1, 1'b0);
        frame_good(24'h889900, 1'b1, 1'b0);
        wait_drain();
        toggle_en = 1'b0;
        expect_counts("backpressure", 16, 2, 0, 6);

        // Reset after beat 4 clears everything
        for (int i = 0; i < 4; i++) begin
            send(24'h99AA00 + 24'(i), i == 0, 1'b0, 1'b0, 1'b1, i == 0, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", {39'd0, out_valid}, 40'd0);
        check("midrst_out_data", {8'd0, out_data}, 40'd0);
        check("midrst_sop_eop", {38'd0, out_startofpacket, out_endofpacket}, 40'd0);
        check("midrst_pulses", {38'd0, frame_done, frame_error}, 40'd0);
        check("midrst_frame_count", {24'd0, frame_count}, 40'd0);
        reset = 1'b0;
        exp_q.delete();
        #1;
        snap();
        frame_good(24'hAABB00, 1'b0, 1'b0);
        wait_drain();
        expect_counts("after_reset", 8, 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/rgba_frame_packer.md
RGBA_FRAME_PACKER -- requirements
Module: rgba_frame_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter ALPHA, default 8'hFF, constant placed in out_data[31:24].
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 in_data  in  24  scaler RGB beat: R[23:16], G[15:8], B[7:0].
REQ-008 in_startofpacket / in_endofpacket / in_valid  in  1 each  Avalon-ST sink qualifiers.
REQ-009 in_ready  out  1  sink ready; a beat is accepted when in_valid and in_ready are both high.
REQ-010 frame_transition  in  1  high means the current frame is abandoned.
REQ-011 out_data  out  32  {ALPHA, in_data}.
REQ-012 out_valid / out_startofpacket / out_endofpacket  out  1 each  source qualifiers.
REQ-013 out_ready  in  1  downstream ready; tie high for a consumer that only takes data/valid.
REQ-014 frame_done / frame_error  out  1 each  single-cycle status pulses.
REQ-015 frame_count  out  16  number of completed good frames; wraps 65535 -> 0.

Function
REQ-016 SHALL implement the states SEEK, STREAM and DRAIN; reset enters SEEK.
REQ-017 In SEEK, in_ready=1; beats without SOP are discarded; an SOP beat with frame_transition=0 is forwarded as pixel (0,0) and the state goes to STREAM.
REQ-018 In STREAM, each accepted beat increments x; at x=WIDTH-1, x wraps to 0 and y increments. Counter widths are $clog2(WIDTH) and $clog2(HEIGHT).
REQ-019 In STREAM, EOP on pixel (WIDTH-1, HEIGHT-1) SHALL be forwarded with out_endofpacket, pulse frame_done, increment frame_count and return to SEEK.
REQ-020 In STREAM, EOP before the last pixel SHALL be forwarded, pulse frame_error and return to SEEK.
REQ-021 In STREAM, the last pixel without EOP SHALL be forwarded with out_endofpacket forced high, pulse frame_error and go to DRAIN.
REQ-022 In DRAIN, in_ready=1; beats are discarded until EOP is accepted, then the state goes to SEEK.
REQ-023 In STREAM, a beat with SOP (and no EOP) SHALL pulse frame_error and restart the frame at (0,0), staying in STREAM.
REQ-024 A beat with SOP and EOP together SHALL be discarded, pulse frame_error, and go to SEEK.
REQ-025 frame_transition=1 in STREAM SHALL discard the current beat, go to DRAIN, and raise no error pulse.
REQ-026 Forwarded beats SHALL pass through a 2-entry buffer; in STREAM, in_ready = buffer not full (registered, no combinational path from out_ready).
REQ-027 Latency SHALL be one cycle: a beat accepted at edge N appears on out_* after edge N when the buffer was empty.
REQ-028 out_* SHALL hold stable while out_valid=1 and out_ready=0; order SHALL be preserved; no beat is lost or duplicated.
REQ-029 Simultaneous buffer push and pop while full SHALL be allowed only if the pop frees the slot; in_ready stays deasserted in that cycle.

Reset
REQ-030 reset SHALL force SEEK, x=y=0, empty buffer, out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, frame_done=0, frame_error=0, frame_count=0, in_ready=0 during reset.
REQ-031 Reset asserted mid-frame SHALL discard buffered beats and emit no error or done pulse; after reset, input is resynchronised at the next SOP.

Structure
REQ-032 Shared package video_stream_pkg SHALL hold the state enum, the RGB/RGBA widths and the default ALPHA.
REQ-033 The 2-entry buffer SHALL be sub-module stream_skid_buffer (parameter DATA_W, carrying data plus SOP/EOP).

Verification (bench parameters WIDTH=4, HEIGHT=2)
REQ-034 Good frame, 8 beats with SOP on 1st and EOP on 8th, out_ready=1 -> 8 outputs, out_data[31:24]=FF, frame_done pulses once, frame_count=1, 1-cycle latency.
REQ-035 3 beats without SOP, then a good frame -> first 3 discarded; exactly 8 outputs.
REQ-036 EOP on 5th beat -> 5 outputs, frame_error pulse, frame_count unchanged; the next good frame completes.
REQ-037 8 beats without EOP, then 2 more with EOP on the 10th -> 8th output has out_endofpacket=1, frame_error pulses, beats 9-10 are dropped.
REQ-038 out_ready toggling 1/0 each cycle plus a random in_valid pattern -> output sequence equals input sequence, with no loss or duplication.
REQ-039 reset high for 1 cycle after beat 4 -> all outputs zero next cycle; the following good frame gives frame_count=1.
